// File: rtl/pd_pulse_seq_ctrl.sv
// Phase-flag sequencer for the pulse-state FSM: times pre/pulse/tail intervals and waits for stateover.
// Optional PD_SEQ_REPEAT_EN adds n_rep/rep_cnt and re-arms for n_rep+1 back-to-back runs.
module pd_pulse_seq_ctrl #(
    parameter int CNT_W  = 16,
    parameter int TO_CYC = 1023
) (
    input  logic             dds,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] t_pre,
    input  logic [CNT_W-1:0] t_pulse,
    input  logic [CNT_W-1:0] t_tail,
    input  logic             stateover,
`ifdef PD_SEQ_REPEAT_EN
    input  logic [7:0]       n_rep,
    output logic [7:0]       rep_cnt,
`endif
    output logic [5:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TO_W = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, ARM, PRE, PULSE, TAIL, WAIT_OVER, DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [TO_W-1:0]  to_cnt, to_n;
    logic [5:0]       flags_n;
    logic             busy_n, done_n, err_n;
    logic [1:0]       mode_q, mode_n;
    logic [CNT_W-1:0] tpre_q, tpre_n, tpul_q, tpul_n, ttail_q, ttail_n;
`ifdef PD_SEQ_REPEAT_EN
    logic [8:0]       rep_q, rep_n;
    logic [7:0]       nrep_q, nrep_n;
    assign rep_cnt = rep_q[7:0];
`endif

    // A programmed duration of zero still occupies one cycle
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] t);
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

    always_ff @(posedge dds or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            to_cnt  <= '0;
            flags   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            mode_q  <= '0;
            tpre_q  <= '0;
            tpul_q  <= '0;
            ttail_q <= '0;
`ifdef PD_SEQ_REPEAT_EN
            rep_q   <= '0;
            nrep_q  <= '0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            to_cnt  <= to_n;
            flags   <= flags_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
            mode_q  <= mode_n;
            tpre_q  <= tpre_n;
            tpul_q  <= tpul_n;
            ttail_q <= ttail_n;
`ifdef PD_SEQ_REPEAT_EN
            rep_q   <= rep_n;
            nrep_q  <= nrep_n;
`endif
        end
    end

    // Outputs are registered: each action listed for a state lands on the edge leaving it,
    // except done, which is raised on entry to DONE so it is visible during that cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        to_n    = to_cnt;
        flags_n = flags;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = err;
        mode_n  = mode_q;
        tpre_n  = tpre_q;
        tpul_n  = tpul_q;
        ttail_n = ttail_q;
`ifdef PD_SEQ_REPEAT_EN
        rep_n   = rep_q;
        nrep_n  = nrep_q;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    mode_n  = mode;
                    tpre_n  = at_least_one(t_pre);
                    tpul_n  = at_least_one(t_pulse);
                    ttail_n = at_least_one(t_tail);
                    busy_n  = 1'b1;
                    err_n   = 1'b0;
`ifdef PD_SEQ_REPEAT_EN
                    rep_n   = '0;
                    nrep_n  = n_rep;
`endif
                    state_n = ARM;
                end
            end
            ARM: begin
                flags_n = {mode_q[0], 3'b000, mode_q[1], 1'b1};
                cnt_n   = tpre_q;
                state_n = PRE;
            end
            PRE: begin
                if (cnt == CNT_W'(1)) begin
                    flags_n[2] = 1'b1;
                    cnt_n      = tpul_q;
                    state_n    = PULSE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt == CNT_W'(1)) begin
                    flags_n[4:3] = 2'b11;
                    cnt_n        = ttail_q;
                    state_n      = TAIL;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            TAIL: begin
                if (cnt == CNT_W'(1)) begin
                    to_n    = '0;
                    state_n = WAIT_OVER;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            WAIT_OVER: begin
                if (!stateover) begin
`ifdef PD_SEQ_REPEAT_EN
                    done_n = (rep_q == {1'b0, nrep_q});
                    rep_n  = rep_q + 9'd1;
`else
                    done_n = 1'b1;
`endif
                    state_n = DONE;
                end else if (to_cnt == TO_W'(TO_CYC - 1)) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    to_n = to_cnt + TO_W'(1);
                end
            end
            DONE: begin
                flags_n = '0;
`ifdef PD_SEQ_REPEAT_EN
                if (!err && rep_q != ({1'b0, nrep_q} + 9'd1)) begin
                    state_n = ARM;
                end else begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
`else
                busy_n  = 1'b0;
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pd_pulse_seq_ctrl.sv
// Self-checking bench for pd_pulse_seq_ctrl: a timeline model predicts every output cycle by cycle.
// Exercises the repeat feature as well when PD_SEQ_REPEAT_EN is defined.
module tb_pd_pulse_seq_ctrl;

    localparam int CNT_W  = 16;
    localparam int TO_CYC = 1023;

    logic             dds = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] t_pre, t_pulse, t_tail;
    logic             stateover;
    logic [5:0]       flags;
    logic             busy, done, err;
    logic [7:0]       rep_obs;
`ifdef PD_SEQ_REPEAT_EN
    logic [7:0]       n_rep;
    logic [7:0]       rep_cnt;
    assign rep_obs = rep_cnt;
`else
    assign rep_obs = 8'h00;
`endif

    int errors = 0;
    int checks = 0;

    pd_pulse_seq_ctrl #(.CNT_W(CNT_W), .TO_CYC(TO_CYC)) dut (
        .dds       (dds),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .t_pre     (t_pre),
        .t_pulse   (t_pulse),
        .t_tail    (t_tail),
        .stateover (stateover),
`ifdef PD_SEQ_REPEAT_EN
        .n_rep     (n_rep),
        .rep_cnt   (rep_cnt),
`endif
        .flags     (flags),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 dds = ~dds;

    function automatic logic [16:0] obsVec();
        return {rep_obs, flags, busy, done, err};
    endfunction

    task automatic checkOutput(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One accepted start; the model lays out each run as a timeline of absolute cycle numbers
    // (cycle 0 = start high, run r's ARM cycle = previous DONE cycle + 1) and predicts from it.
    task automatic applyStimulus(input string name, input logic [1:0] m, input int p, input int u,
                                 input int t, input int d, input int nrep, input int rstAt);
        int  pe, ue, te, nruns, lastE, repExp;
        int  bse[256], wA[256], eA[256];
        bit  tmo;
        logic [5:0]  fExp;
        logic [16:0] exp;
        pe = (p == 0) ? 1 : p;
        ue = (u == 0) ? 1 : u;
        te = (t == 0) ? 1 : t;
        tmo = (d > TO_CYC - 1);
        nruns = tmo ? 1 : nrep + 1;
        for (int r = 0; r < nruns; r++) begin
            bse[r] = (r == 0) ? 0 : eA[r-1];
            wA[r]  = bse[r] + 2 + pe + ue + te;
            eA[r]  = tmo ? wA[r] + TO_CYC : wA[r] + d + 1;
        end
        lastE = eA[nruns-1];

        start   = 1'b1;
        mode    = m;
        t_pre   = CNT_W'(p);
        t_pulse = CNT_W'(u);
        t_tail  = CNT_W'(t);
`ifdef PD_SEQ_REPEAT_EN
        n_rep   = 8'(nrep);
`endif
        for (int c = 1; c <= lastE + 2; c++) begin
            @(posedge dds);
            #1;
            if (c == rstAt) begin
                rst = 1'b1;
                #1;
                checkOutput($sformatf("%s async_rst c=%0d", name, c), obsVec(), 17'h0);
                #1;
                rst = 1'b0;
                start = 1'b0;
                stateover = 1'b1;
                return;
            end
            fExp = '0;
            repExp = 0;
            for (int r = 0; r < nruns; r++) begin
                if (c >= bse[r] + 2 && c <= eA[r])
                    fExp = fExp | {m[0], 3'b000, m[1], 1'b1};
                if (c >= bse[r] + 2 + pe && c <= eA[r])
                    fExp[2] = 1'b1;
                if (c >= bse[r] + 2 + pe + ue && c <= eA[r])
                    fExp[4:3] = 2'b11;
                if (!tmo && c >= eA[r])
                    repExp++;
            end
`ifndef PD_SEQ_REPEAT_EN
            repExp = 0;
`endif
            exp = {8'(repExp), fExp, (c <= lastE), (c == lastE && !tmo), (tmo && c >= lastE)};
            checkOutput($sformatf("%s c=%0d", name, c), obsVec(), exp);

            start   = (c == 3);
            mode    = 2'($urandom_range(0, 3));
            t_pre   = CNT_W'($urandom_range(0, 9));
            t_pulse = CNT_W'($urandom_range(0, 9));
            t_tail  = CNT_W'($urandom_range(0, 9));
`ifdef PD_SEQ_REPEAT_EN
            n_rep   = 8'($urandom_range(0, 9));
`endif
            stateover = 1'b1;
            for (int r = 0; r < nruns; r++)
                if (!tmo && c >= wA[r] + d && c <= eA[r]) stateover = 1'b0;
        end
        start = 1'b0;
        stateover = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 2'b00;
        t_pre = '0;
        t_pulse = '0;
        t_tail = '0;
        stateover = 1'b1;
`ifdef PD_SEQ_REPEAT_EN
        n_rep = 8'd0;
`endif
        #12;
        checkOutput("reset", obsVec(), 17'h0);
        @(negedge dds);
        rst = 1'b0;
        @(posedge dds);
        #1;

        $display("[TB] directed runs");
        applyStimulus("basic",    2'b00, 5, 3, 2, 4, 0, 0);
        applyStimulus("mode11",   2'b11, 4, 2, 3, 1, 0, 0);
        applyStimulus("zero",     2'b01, 0, 0, 0, 0, 0, 0);
        applyStimulus("early_so", 2'b10, 2, 1, 1, 0, 0, 0);
        applyStimulus("timeout",  2'b01, 3, 2, 2, 5000, 0, 0);
        applyStimulus("post_to",  2'b00, 1, 2, 1, 2, 0, 0);
        applyStimulus("rst_mid",  2'b11, 3, 4, 2, 3, 0, 6);
        applyStimulus("after_rst",2'b10, 2, 2, 2, 1, 0, 0);
`ifdef PD_SEQ_REPEAT_EN
        applyStimulus("repeat",   2'b11, 2, 3, 1, 2, 2, 0);
`endif

        $display("[TB] random runs");
        for (int k = 0; k < 8; k++) begin
            int nr;
`ifdef PD_SEQ_REPEAT_EN
            nr = $urandom_range(0, 2);
`else
            nr = 0;
`endif
            applyStimulus($sformatf("rand%0d", k), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                          $urandom_range(0, 5), nr, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
